// File: rtl/arith_nibble_sequencer.sv
// arith_nibble_sequencer
// Control stage around an external 4-bit combinational arithmetic unit.
// A WIDTH-bit request is taken over a valid/ready handshake. Its operands
// are streamed to the unit one nibble per cycle, least significant nibble
// first, with the carry chained between nibbles. The collected result and
// its carry, zero and signed-overflow flags are returned over a second
// valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op, req_x, req_y   operation code and operands
//   rsp_valid/rsp_ready    response handshake (valid only in DONE)
//   rsp_d, rsp_cout,       result, carry out (1 = no borrow for SUB/DEC),
//   rsp_zero, rsp_ovf      zero flag, signed overflow flag
//   au_x, au_y, au_cin,    nibble operands, carry in and operand select
//   au_s, au_a, au_b       driven to the arithmetic unit (a tied 0, b tied 1)
//   au_d, au_cout          nibble sum and carry from the arithmetic unit
module arith_nibble_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_d,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic [3:0]       au_x,
  output logic [3:0]       au_y,
  output logic             au_cin,
  output logic [1:0]       au_s,
  output logic             au_a,
  output logic             au_b,
  input  logic [3:0]       au_d,
  input  logic             au_cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [1:0]        sel_q, sel_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              chain_q, chain_d;
  logic              cf_q, cf_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  assembled;
  logic              eff_y_msb;
  logic [1:0]        dec_sel;
  logic              dec_cin;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_d     = res_q;
  assign rsp_cout  = cout_q;
  assign rsp_zero  = zero_q;
  assign rsp_ovf   = ovf_q;
  assign au_a      = 1'b0;
  assign au_b      = 1'b1;

  // Op code to operand select and initial carry; 110/111 behave as PASS.
  always_comb begin
    dec_sel = 2'b10;
    dec_cin = 1'b0;
    case (req_op)
      3'b000: begin dec_sel = 2'b00; dec_cin = 1'b0; end
      3'b001: begin dec_sel = 2'b00; dec_cin = cf_q; end
      3'b010: begin dec_sel = 2'b01; dec_cin = 1'b1; end
      3'b011: begin dec_sel = 2'b10; dec_cin = 1'b1; end
      3'b100: begin dec_sel = 2'b11; dec_cin = 1'b0; end
      default: begin dec_sel = 2'b10; dec_cin = 1'b0; end
    endcase
  end

  // Next-state logic, arithmetic unit drive and result assembly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    chain_d = chain_q;
    cf_d    = cf_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    au_x    = 4'h0;
    au_y    = 4'h0;
    au_cin  = 1'b0;
    au_s    = 2'b00;

    // Result as it will look once the current nibble is written; the zero
    // flag must see the final nibble, which is not yet registered.
    assembled = res_q;
    assembled[{idx_q, 2'b00} +: 4] = au_d;

    eff_y_msb = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          sel_d   = dec_sel;
          chain_d = dec_cin;
          x_d     = req_x;
          y_d     = req_y;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        au_x   = x_q[{idx_q, 2'b00} +: 4];
        au_y   = y_q[{idx_q, 2'b00} +: 4];
        au_cin = chain_q;
        au_s   = sel_q;
        res_d   = assembled;
        chain_d = au_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NIB - 1)) begin
          // Sign of the operand the unit actually added in the top nibble.
          case (sel_q)
            2'b00:   eff_y_msb = au_y[3];
            2'b01:   eff_y_msb = ~au_y[3];
            2'b10:   eff_y_msb = 1'b0;
            default: eff_y_msb = 1'b1;
          endcase
          state_d = DONE;
          idx_d   = '0;
          cout_d  = au_cout;
          cf_d    = au_cout;
          zero_d  = (assembled == '0);
          ovf_d   = (au_x[3] == eff_y_msb) && (au_d[3] != au_x[3]);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= 2'b00;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      chain_q <= 1'b0;
      cf_q    <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      chain_q <= chain_d;
      cf_q    <= cf_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
